cam_capture_ctrl: RTL and testbench

CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

---
 rtl/cam_capture_ctrl_pkg.sv | 17 +
 rtl/cam_capture_ctrl_sync_edge.sv | 34 +++
 rtl/cam_capture_ctrl.sv | 153 +++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_ctrl_pkg.sv
// Shared definitions for the camera capture controller: FSM encoding,
// default frame geometry and the packed RGB565 pixel width.
package cam_capture_ctrl_pkg;

    localparam int DEF_H_PIXELS = 160;
    localparam int DEF_V_LINES  = 120;
    localparam int PIXEL_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_VS_HI = 3'd1,
        ST_WAIT_VS_LO = 3'd2,
        ST_ACTIVE     = 3'd3,
        ST_FINISH     = 3'd4
    } cap_state_t;

endpackage

// File: rtl/cam_capture_ctrl_sync_edge.sv
// Multi-flop synchronizer for one asynchronous camera line, with
// single-cycle rise/fall pulses derived from the synchronized value.
module cam_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              q_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
            q_d  <= 1'b0;
        end else begin
            sync[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync[i] <= sync[i-1];
            end
            q_d <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Captures one camera frame per start request, packing byte pairs into
// RGB565 pixels for a downstream FIFO and flagging overflow/geometry errors.
module cam_capture_ctrl
    import cam_capture_ctrl_pkg::*;
#(
    parameter int H_PIXELS    = DEF_H_PIXELS,
    parameter int V_LINES     = DEF_V_LINES,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err_overflow,
    output logic               err_geometry,
    input  logic               cam_pclk,
    input  logic               cam_href,
    input  logic               cam_vsync,
    input  logic [7:0]         cam_data,
    input  logic               fifo_full,
    output logic               fifo_wr,
    output logic [PIXEL_W-1:0] fifo_data,
    output cap_state_t         dbg_state
);

    localparam int PIX_W  = $clog2(H_PIXELS + 2);
    localparam int LINE_W = $clog2(V_LINES + 1);
    localparam logic [PIX_W-1:0]  PIX_TARGET  = PIX_W'(H_PIXELS);
    localparam logic [PIX_W-1:0]  PIX_SAT     = PIX_W'(H_PIXELS + 1);
    localparam logic [LINE_W-1:0] LINE_TARGET = LINE_W'(V_LINES);

    cap_state_t        state, state_next;
    logic [PIX_W-1:0]  pix_cnt;
    logic [LINE_W-1:0] line_cnt;
    logic              byte_phase;
    logic [7:0]        hi_byte;
    logic [7:0]        data_sync [SYNC_STAGES];
    logic [7:0]        byte_q;

    logic pclk_rise, href_q, href_fall, vsync_q, vsync_rise, vsync_fall;
    logic unused_pclk_q, unused_pclk_fall, unused_href_rise;

    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
        .clk(clk), .reset(reset), .d(cam_pclk),
        .q(unused_pclk_q), .rise(pclk_rise), .fall(unused_pclk_fall)
    );

    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_href (
        .clk(clk), .reset(reset), .d(cam_href),
        .q(href_q), .rise(unused_href_rise), .fall(href_fall)
    );

    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
        .clk(clk), .reset(reset), .d(cam_vsync),
        .q(vsync_q), .rise(vsync_rise), .fall(vsync_fall)
    );

    // Data bus takes the same number of stages as pclk so the byte and its
    // strobe edge line up at the synchronized side.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync[i] <= '0;
            end
        end else begin
            data_sync[0] <= cam_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync[i] <= data_sync[i-1];
            end
        end
    end

    assign byte_q    = data_sync[SYNC_STAGES-1];
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != ST_IDLE);
        done       = 1'b0;
        case (state)
            ST_IDLE:       if (start) state_next = ST_WAIT_VS_HI;
            ST_WAIT_VS_HI: if (vsync_q) state_next = ST_WAIT_VS_LO;
            ST_WAIT_VS_LO: if (vsync_fall) state_next = ST_ACTIVE;
            ST_ACTIVE: begin
                if (vsync_rise || (line_cnt == LINE_TARGET)) state_next = ST_FINISH;
            end
            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default:       state_next = ST_IDLE;
        endcase
    end

    // FIFO interface: fifo_wr is a one-cycle strobe qualifying fifo_data.
    // There is no backpressure; a pixel completing while fifo_full=1 is
    // dropped and recorded in err_overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt      <= '0;
            line_cnt     <= '0;
            byte_phase   <= 1'b0;
            hi_byte      <= '0;
            fifo_wr      <= 1'b0;
            fifo_data    <= '0;
            err_overflow <= 1'b0;
            err_geometry <= 1'b0;
        end else begin
            fifo_wr <= 1'b0;
            if ((state == ST_IDLE) && start) begin
                pix_cnt      <= '0;
                line_cnt     <= '0;
                byte_phase   <= 1'b0;
                err_overflow <= 1'b0;
                err_geometry <= 1'b0;
            end
            if (state == ST_ACTIVE) begin
                if (pclk_rise && href_q) begin
                    byte_phase <= ~byte_phase;
                    if (!byte_phase) begin
                        hi_byte <= byte_q;
                    end else begin
                        if (pix_cnt != PIX_SAT) pix_cnt <= pix_cnt + 1'b1;
                        if (fifo_full) begin
                            err_overflow <= 1'b1;
                        end else if (state_next == ST_ACTIVE) begin
                            fifo_wr   <= 1'b1;
                            fifo_data <= {hi_byte, byte_q};
                        end
                    end
                end
                if (href_fall) begin
                    byte_phase <= 1'b0;
                    pix_cnt    <= '0;
                    if (line_cnt != LINE_TARGET) line_cnt <= line_cnt + 1'b1;
                    if ((pix_cnt != PIX_TARGET) || byte_phase) err_geometry <= 1'b1;
                end
                // A vsync before the expected line count means a short frame.
                if (vsync_rise && (line_cnt != LINE_TARGET)) err_geometry <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl: table of frame shapes, hand-written corner
// sequences and random frames checked against a byte-pairing frame model.
module tb_cam_capture_ctrl;
  import cam_capture_ctrl_pkg::*;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cam_pclk = 1'b0;
  logic        cam_href = 1'b0;
  logic        cam_vsync = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        fifo_full = 1'b0;
  logic        busy, done, err_overflow, err_geometry, fifo_wr;
  logic [15:0] fifo_data;
  cap_state_t  dbg_state;

  cam_capture_ctrl #(.H_PIXELS(H), .V_LINES(V), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .err_overflow(err_overflow), .err_geometry(err_geometry),
    .cam_pclk(cam_pclk), .cam_href(cam_href), .cam_vsync(cam_vsync),
    .cam_data(cam_data), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // scoreboard state
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  bit prev_wr = 1'b0;

  // frame plan and model
  int         plan_nb[3];
  bit         plan_full[3][8];
  bit         seq_mode = 1'b1;
  logic [7:0] byte_ctr = 8'h01;
  logic [7:0] m_hi;
  int         m_writes;
  bit         m_ovf, m_geo;
  bit         extra_start = 1'b0;

  typedef struct {
    string name;
    int    n_lines;
    int    nb0;
    int    nb1;
    int    nb2;
    int    full_line;
    int    full_pix;
    bit    exp_ovf;
    bit    exp_geo;
    int    exp_wr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fifo_wr) begin
      wr_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got %04h expected none", fifo_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (fifo_data !== e) begin
          n_fail++;
          $display("FAIL fifo_data: got %04h expected %04h", fifo_data, e);
        end
      end
      n_checks++;
      if (prev_wr) begin
        n_fail++;
        $display("FAIL wr_back_to_back: got 2 consecutive strobes expected 1");
      end
      n_checks++;
      if (!busy) begin
        n_fail++;
        $display("FAIL wr_while_idle: got busy=0 expected busy=1");
      end
    end
    prev_wr = fifo_wr;
    if (done) done_cnt++;
  end

  function automatic logic [7:0] gen_byte();
    logic [7:0] v;
    if (seq_mode) begin
      v = byte_ctr;
      byte_ctr = byte_ctr + 8'd1;
    end else begin
      v = 8'($urandom_range(0, 255));
    end
    return v;
  endfunction

  task automatic model_reset();
    m_writes = 0;
    m_ovf    = 1'b0;
    m_geo    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    #10 start = 1'b0;
  endtask

  // Bytes pair up within a line; only the first V lines of a capture count.
  task automatic drive_bytes(input int nbytes, input int line_idx, input bit capture);
    for (int b = 0; b < nbytes; b++) begin
      logic [7:0] v;
      bit full;
      v = gen_byte();
      full = (b % 2 == 1) && plan_full[line_idx][b/2];
      cam_data  = v;
      fifo_full = full;
      if (b % 2 == 0) begin
        m_hi = v;
      end else if (capture && line_idx < V) begin
        if (full) m_ovf = 1'b1;
        else begin
          exp_q.push_back({m_hi, v});
          m_writes++;
        end
      end
      #30 cam_pclk = 1'b1;
      #30 cam_pclk = 1'b0;
    end
  endtask

  task automatic drive_line(input int nbytes, input int line_idx, input bit capture);
    cam_href = 1'b1;
    drive_bytes(nbytes, line_idx, capture);
    fifo_full = 1'b0;
    cam_href  = 1'b0;
    if (capture && line_idx < V && nbytes != 2 * H) m_geo = 1'b1;
    #60;
  endtask

  task automatic drive_frame(input int n_lines, input bit capture);
    cam_vsync = 1'b1;
    #100;
    if (extra_start) begin
      pulse_start();
      #40;
    end
    cam_vsync = 1'b0;
    #100;
    for (int l = 0; l < n_lines; l++) begin
      drive_line(plan_nb[l], l, capture);
      if (extra_start && l == 0) pulse_start();
    end
    #40 cam_vsync = 1'b1;
    #100 cam_vsync = 1'b0;
    #60;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400 && busy; i++) #10;
    chk({tag, " idle_timeout"}, busy, 1'b0);
  endtask

  task automatic set_plan(input vec_t v);
    plan_nb[0] = v.nb0;
    plan_nb[1] = v.nb1;
    plan_nb[2] = v.nb2;
    for (int l = 0; l < 3; l++)
      for (int p = 0; p < 8; p++) plan_full[l][p] = 1'b0;
    if (v.full_line >= 0) plan_full[v.full_line][v.full_pix] = 1'b1;
  endtask

  task automatic run_frame(input int n_lines, input string tag, input bit use_model,
                           input int e_wr, input bit e_ovf, input bit e_geo);
    int wr0, dn0;
    model_reset();
    if (n_lines < V) m_geo = 1'b1;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    pulse_start();
    chk({tag, " busy_after_start"}, busy, 1'b1);
    drive_frame(n_lines, 1'b1);
    wait_idle(tag);
    chk({tag, " done_count"}, done_cnt - dn0, 1);
    chk({tag, " writes"}, wr_cnt - wr0, use_model ? m_writes : e_wr);
    chk({tag, " err_overflow"}, err_overflow, use_model ? m_ovf : e_ovf);
    chk({tag, " err_geometry"}, err_geometry, use_model ? m_geo : e_geo);
    chk({tag, " missing_writes"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int wr0, dn0;
    vecs[0] = '{"full_frame",   2, 8,  8, 0, -1, -1, 1'b0, 1'b0, 8};
    vecs[1] = '{"ovf_pix3",     2, 8,  8, 0,  0,  2, 1'b1, 1'b0, 7};
    vecs[2] = '{"short_line2",  2, 8,  6, 0, -1, -1, 1'b0, 1'b1, 7};
    vecs[3] = '{"one_line",     1, 8,  0, 0, -1, -1, 1'b0, 1'b1, 4};
    vecs[4] = '{"extra_line",   3, 8,  8, 8, -1, -1, 1'b0, 1'b0, 8};
    vecs[5] = '{"odd_bytes",    2, 7,  8, 0, -1, -1, 1'b0, 1'b1, 7};
    vecs[6] = '{"long_line",    2, 12, 8, 0,  0,  1, 1'b1, 1'b1, 9};
    vecs[7] = '{"ovf_last",     2, 8,  8, 0,  1,  3, 1'b1, 1'b0, 7};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset fifo_wr", fifo_wr, 1'b0);
    chk("reset err_overflow", err_overflow, 1'b0);
    chk("reset err_geometry", err_geometry, 1'b0);
    chk("reset fifo_data", fifo_data, 16'h0000);
    chk("reset state", dbg_state, ST_IDLE);
    reset = 1'b0;
    #3;

    // camera running while idle
    set_plan(vecs[0]);
    wr0 = wr_cnt;
    drive_frame(2, 1'b0);
    chk("idle_activity writes", wr_cnt - wr0, 0);
    chk("idle_activity busy", busy, 1'b0);

    // table of frame shapes
    for (int r = 0; r < 8; r++) begin
      set_plan(vecs[r]);
      seq_mode = 1'b1;
      byte_ctr = 8'h01;
      run_frame(vecs[r].n_lines, vecs[r].name, 1'b0,
                vecs[r].exp_wr, vecs[r].exp_ovf, vecs[r].exp_geo);
    end

    // start while a frame is already in progress
    set_plan(vecs[0]);
    byte_ctr = 8'h40;
    wr0 = wr_cnt;
    dn0 = done_cnt;
    pulse_start();
    drive_line(8, 0, 1'b0);
    drive_line(8, 1, 1'b0);
    chk("midframe no_writes", wr_cnt - wr0, 0);
    chk("midframe still_busy", busy, 1'b1);
    model_reset();
    drive_frame(2, 1'b1);
    wait_idle("midframe");
    chk("midframe done_count", done_cnt - dn0, 1);
    chk("midframe writes", wr_cnt - wr0, m_writes);
    chk("midframe err_geometry", err_geometry, 1'b0);
    chk("midframe missing_writes", exp_q.size(), 0);
    exp_q.delete();

    // reset during line 1
    set_plan(vecs[0]);
    byte_ctr = 8'h01;
    dn0 = done_cnt;
    model_reset();
    pulse_start();
    cam_vsync = 1'b1;
    #100 cam_vsync = 1'b0;
    #100 cam_href = 1'b1;
    drive_bytes(4, 0, 1'b1);
    #20;
    chk("rst_mid pre_writes", exp_q.size(), 0);
    reset = 1'b1;
    #10 reset = 1'b0;
    chk("rst_mid busy", busy, 1'b0);
    chk("rst_mid done", done, 1'b0);
    chk("rst_mid fifo_wr", fifo_wr, 1'b0);
    chk("rst_mid err_overflow", err_overflow, 1'b0);
    chk("rst_mid err_geometry", err_geometry, 1'b0);
    chk("rst_mid fifo_data", fifo_data, 16'h0000);
    exp_q.delete();
    drive_bytes(4, 0, 1'b0);
    fifo_full = 1'b0;
    cam_href = 1'b0;
    #60 cam_vsync = 1'b1;
    #100 cam_vsync = 1'b0;
    #60;
    chk("rst_mid no_done", done_cnt - dn0, 0);
    byte_ctr = 8'h01;
    run_frame(2, "after_reset", 1'b0, 8, 1'b0, 1'b0);

    // extra start pulses while busy
    byte_ctr = 8'h01;
    extra_start = 1'b1;
    run_frame(2, "start_while_busy", 1'b0, 8, 1'b0, 1'b0);
    extra_start = 1'b0;
    chk("start_while_busy idle_after", busy, 1'b0);

    // random frames against the model
    seq_mode = 1'b0;
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int l = 0; l < 3; l++) begin
        plan_nb[l] = 2 * int'($urandom_range(3, 5)) + (($urandom_range(0, 5) == 0) ? 1 : 0);
        for (int p = 0; p < 8; p++) plan_full[l][p] = ($urandom_range(0, 7) == 0);
      end
      run_frame(n, "random", 1'b1, 0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
